// File: rtl/uart_loader_if.sv
// Memory write bus between the UART loader (initiator) and program memory.
interface uart_loader_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (output mem_addr, output mem_wdata, output mem_wstrb);
  modport slave  (input  mem_addr, input  mem_wdata, input  mem_wstrb);
endinterface

// File: rtl/uart_loader.sv
// UART program loader: 8N1 byte receiver feeding a frame parser that writes
// 32-bit words into program memory. busy holds the CPU in reset mid-frame.
module uart_loader #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  uart_loader_if.master mem,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       SYNC    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_COUNT, P_DATA, P_CSUM} p_st_t;

  // ---------------- byte receiver ----------------
  logic             sync1_q, sync2_q, rx_prev_q;
  rx_st_t           rx_st_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_sh_q;
  logic             byte_valid_q, frame_err_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // Idle level is high, so all three reset to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Bit timing FSM: re-check the start bit at mid-bit (rejects glitches),
  // then sample data and stop bits every bit period from that point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st_q      <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_prev_q && !sync2_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == FULL_M1) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {sync2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == FULL_M1) begin
            rx_cnt_q <= '0;
            rx_st_q  <= RX_IDLE;
            if (sync2_q) byte_valid_q <= 1'b1;
            else         frame_err_q  <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- frame parser ----------------
  p_st_t       p_st_q;
  logic [1:0]  bidx_q;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] wcnt_q;
  logic [7:0]  sum_q;
  logic [3:0]  wstrb_q;
  logic        busy_q, done_q, err_q;

  // Frame parser with registered bus and status outputs. Multi-byte fields
  // shift in from the top so little-endian bytes land in place after the
  // last byte. The address advances the cycle after each write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_st_q  <= P_IDLE;
      bidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      sum_q   <= '0;
      wstrb_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wstrb_q <= 4'b0000;
      if (wstrb_q != 4'b0000) addr_q <= addr_q + 32'd4;

      if (frame_err_q) begin
        // A broken byte mid-frame aborts; in IDLE it is line noise.
        if (p_st_q != P_IDLE) begin
          p_st_q <= P_IDLE;
          busy_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end else if (byte_valid_q) begin
        case (p_st_q)
          P_IDLE: begin
            if (rx_sh_q == SYNC) begin
              p_st_q <= P_ADDR;
              busy_q <= 1'b1;
              err_q  <= 1'b0;
              sum_q  <= '0;
              bidx_q <= '0;
            end
          end
          P_ADDR: begin
            sum_q  <= sum_q + rx_sh_q;
            bidx_q <= bidx_q + 1'b1;
            if (bidx_q == 2'd3) begin
              addr_q <= {rx_sh_q, addr_q[31:10], 2'b00};
              p_st_q <= P_COUNT;
            end else begin
              addr_q <= {rx_sh_q, addr_q[31:8]};
            end
          end
          P_COUNT: begin
            sum_q <= sum_q + rx_sh_q;
            if (bidx_q == 2'd0) begin
              wcnt_q[7:0] <= rx_sh_q;
              bidx_q      <= 2'd1;
            end else begin
              wcnt_q <= {rx_sh_q, wcnt_q[7:0]};
              bidx_q <= 2'd0;
              p_st_q <= ({rx_sh_q, wcnt_q[7:0]} == 16'd0) ? P_CSUM : P_DATA;
            end
          end
          P_DATA: begin
            sum_q   <= sum_q + rx_sh_q;
            wdata_q <= {rx_sh_q, wdata_q[31:8]};
            bidx_q  <= bidx_q + 1'b1;
            if (bidx_q == 2'd3) begin
              wstrb_q <= 4'b1111;
              wcnt_q  <= wcnt_q - 1'b1;
              if (wcnt_q == 16'd1) p_st_q <= P_CSUM;
            end
          end
          P_CSUM: begin
            if (rx_sh_q == sum_q) done_q <= 1'b1;
            else                  err_q  <= 1'b1;
            busy_q <= 1'b0;
            p_st_q <= P_IDLE;
          end
          default: p_st_q <= P_IDLE;
        endcase
      end
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of frames plus hand-written corner sequences.
module tb_uart_loader;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rx = 1'b1;
  logic busy, done, err;
  uart_loader_if bus();

  uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit busy_seen = 1'b0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  fb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus monitor: log writes, check strobe shape and post-write address advance.
  bit          prev_wstrb = 1'b0;
  logic [31:0] prev_addr  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_wstrb = 1'b0;
    end else begin
      if (prev_wstrb) chk("addr_advance", bus.mem_addr, prev_addr + 32'd4);
      if (bus.mem_wstrb != 4'b0000) begin
        chk("wstrb_value", {28'd0, bus.mem_wstrb}, 32'h0000000F);
        chk("wstrb_one_cycle", {31'd0, prev_wstrb}, 32'd0);
        wr_addr.push_back(bus.mem_addr);
        wr_data.push_back(bus.mem_wdata);
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_with_done", {31'd0, busy}, 32'd0);
      end
      if (busy) busy_seen = 1'b1;
      prev_wstrb = (bus.mem_wstrb != 4'b0000);
      prev_addr  = bus.mem_addr;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    uart_rx = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i]; cyc(CPB);
    end
    uart_rx = stop; cyc(CPB);
    uart_rx = 1'b1; cyc(3);
  endtask

  // Frame bytes after sync; checksum = byte sum + adj.
  task automatic build(input logic [31:0] a, input int n, input logic [31:0] w0,
                       input logic [31:0] w1, input logic [7:0] adj);
    logic [7:0] s;
    logic [31:0] w;
    fb.delete();
    for (int i = 0; i < 4; i++) fb.push_back(a[8*i +: 8]);
    fb.push_back(8'(n));
    fb.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) fb.push_back(w[8*i +: 8]);
    end
    s = 8'h00;
    foreach (fb[i]) s = s + fb[i];
    fb.push_back(s + adj);
  endtask

  // Send sync + fb. bad_at: index into fb with a 0 stop bit (stop there).
  // glitch_after: index into fb after which a 1-cycle low pulse is injected.
  task automatic send_frame(input int bad_at, input int glitch_after);
    send_byte(8'hA5, 1'b1);
    chk("busy_after_sync", {31'd0, busy}, 32'd1);
    chk("err_clear_on_sync", {31'd0, err}, 32'd0);
    foreach (fb[i]) begin
      if (i == bad_at) begin
        send_byte(fb[i], 1'b0);
        break;
      end
      send_byte(fb[i], 1'b1);
      if (i == glitch_after) begin
        uart_rx = 1'b0; cyc(1);
        uart_rx = 1'b1; cyc(3 * CPB);
      end
    end
    cyc(CPB);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          n;
    logic [31:0] w0, w1;
    logic [7:0]  adj;
    int          exp_wr;
    logic [31:0] ea0, ea1;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{32'h00000100, 2, 32'hDEADBEEF, 32'h12345678, 8'd0, 2, 32'h00000100, 32'h00000104, 1, 1'b0};
    vt[1] = '{32'h00000200, 1, 32'hCAFEF00D, 32'h0,        8'd1, 1, 32'h00000200, 32'h0,        0, 1'b1};
    vt[2] = '{32'h00000040, 0, 32'h0,        32'h0,        8'd0, 0, 32'h0,        32'h0,        1, 1'b0};
    vt[3] = '{32'hFFFFFFFE, 2, 32'h11111111, 32'h22222222, 8'd0, 2, 32'hFFFFFFFC, 32'h00000000, 1, 1'b0};

    // Reset state
    cyc(3);
    chk("rst_addr",  bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    rst = 1'b1;
    cyc(5);

    // Noise in IDLE
    clear_log();
    busy_seen = 1'b0;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    cyc(CPB);
    chk("noise_busy_seen", {31'd0, busy_seen}, 32'd0);
    chk("noise_writes", wr_addr.size(), 32'd0);
    chk("noise_done", done_cnt, 32'd0);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      clear_log();
      build(vt[v].addr, vt[v].n, vt[v].w0, vt[v].w1, vt[v].adj);
      send_frame(-1, -1);
      chk($sformatf("v%0d_nwr", v), wr_addr.size(), vt[v].exp_wr);
      if (wr_addr.size() == vt[v].exp_wr) begin
        for (int k = 0; k < vt[v].exp_wr; k++) begin
          chk($sformatf("v%0d_addr%0d", v, k), wr_addr[k], (k == 0) ? vt[v].ea0 : vt[v].ea1);
          chk($sformatf("v%0d_data%0d", v, k), wr_data[k], (k == 0) ? vt[v].w0 : vt[v].w1);
        end
      end
      chk($sformatf("v%0d_done", v), done_cnt, vt[v].exp_done);
      chk($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vt[v].exp_err});
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
    end

    // Framing error on the 3rd byte of the second word (fb index 6+4+2 = 12)
    clear_log();
    build(32'h00000300, 2, 32'hA1B2C3D4, 32'h55667788, 8'd0);
    send_frame(12, -1);
    chk("ferr_nwr", wr_addr.size(), 32'd1);
    chk("ferr_err", {31'd0, err}, 32'd1);
    chk("ferr_busy", {31'd0, busy}, 32'd0);
    chk("ferr_done", done_cnt, 32'd0);
    send_byte(8'h00, 1'b1);
    chk("err_sticky_idle", {31'd0, err}, 32'd1);

    // Glitch between data bytes must not produce a byte
    clear_log();
    build(32'h00000400, 1, 32'h0BADF00D, 32'h0, 8'd0);
    send_frame(-1, 7);
    chk("glitch_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("glitch_addr", wr_addr[0], 32'h00000400);
      chk("glitch_data", wr_data[0], 32'h0BADF00D);
    end
    chk("glitch_done", done_cnt, 32'd1);
    chk("glitch_err", {31'd0, err}, 32'd0);
    // Framing error in IDLE leaves err alone
    send_byte(8'h33, 1'b0);
    cyc(CPB);
    chk("idle_ferr_err", {31'd0, err}, 32'd0);
    chk("idle_ferr_busy", {31'd0, busy}, 32'd0);

    // Reset while the write strobe of the first word is active
    clear_log();
    build(32'h00000500, 2, 32'h01020304, 32'h05060708, 8'd0);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(fb[i], 1'b1);
    fork
      send_byte(fb[9], 1'b1);
      begin : wait_strobe
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 20 * CPB && !hit; c++) begin
          @(negedge clk);
          if (bus.mem_wstrb != 4'b0000) hit = 1'b1;
        end
        chk("rst_mid_strobe_seen", {31'd0, hit}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstm_addr",  bus.mem_addr, 32'h0);
        chk("rstm_wdata", bus.mem_wdata, 32'h0);
        chk("rstm_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
        chk("rstm_busy",  {31'd0, busy}, 32'd0);
        chk("rstm_done",  {31'd0, done}, 32'd0);
        chk("rstm_err",   {31'd0, err}, 32'd0);
      end
    join
    cyc(5);
    rst = 1'b1;
    cyc(5);
    clear_log();
    build(32'h00000600, 1, 32'hFEEDFACE, 32'h0, 8'd0);
    send_frame(-1, -1);
    chk("post_rst_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("post_rst_addr", wr_addr[0], 32'h00000600);
      chk("post_rst_data", wr_data[0], 32'hFEEDFACE);
    end
    chk("post_rst_done", done_cnt, 32'd1);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
# uart_loader

UART program loader that acts as a second initiator on the SoC memory bus. It receives framed bytes on a UART pin and writes 32-bit words into program memory. While a frame is in progress it holds `busy` high, which the top level uses to keep the CPU in reset. It is the write-side counterpart of the CPU's instruction-fetch path into `progmem`.

## Interface
- `CLK_FREQ`, default 12000000: system clock in Hz.
- `BAUD`, default 115200: UART bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division), which is 104 at the defaults.

Ports (name, direction, width, meaning):
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `uart_rx`, input, 1: serial input. Idles high; 8N1 framing, LSB first.
- `mem_addr`, output, 32: byte address of the write. Bits [1:0] are always 0.
- `mem_wdata`, output, 32: write data.
- `mem_wstrb`, output, 4: byte write strobe. It is either `4'b1111` for one cycle or `4'b0000`.
- `busy`, output, 1: high while a frame is being parsed.
- `done`, output, 1: one-cycle pulse when a frame completes with a good checksum.
- `err`, output, 1: sticky error flag for a checksum or framing error.

## Operation
- **Reset values:** all outputs are 0; the parser is in IDLE; the synchronizer flops are 1.
- **Byte receiver:**
  - `uart_rx` passes through a 2-FF synchronizer.
  - In RX_IDLE, a high-to-low transition starts the bit counter.
  - The start bit is re-sampled at `CLKS_PER_BIT/2`. If it reads 1, the receiver returns to RX_IDLE with no error.
  - The 8 data bits are then sampled every `CLKS_PER_BIT` cycles, LSB first, followed by the stop bit.
  - Stop bit = 1: `byte_valid` pulses for one cycle with the byte.
  - Stop bit = 0: a framing error is signalled and no `byte_valid` is produced.
- **Frame format (bytes in order):**
  - Sync byte `0xA5`.
  - Address, 4 bytes, little-endian.
  - Word count N, 2 bytes, little-endian.
  - N×4 data bytes; each word is little-endian.
  - Checksum, 1 byte: the 8-bit sum mod 256 of every byte after sync and before the checksum.
- **Parser states:**
  - IDLE: a byte other than `0xA5` is ignored. On `0xA5`: go to ADDR, set `busy`=1, clear `err`, clear the running sum.
  - ADDR: collects 4 bytes, then goes to COUNT. Address bits [1:0] are forced to 0.
  - COUNT: collects 2 bytes. If N=0, go to CSUM; otherwise go to DATA.
  - DATA: collects 4 bytes per word. On the 4th byte, issue a write and decrement the remaining count. When the count reaches 0, go to CSUM.
  - CSUM: compare the received checksum with the running sum.
    - Match: `done` pulses.
    - Mismatch: `err`=1.
    - In both cases: go to IDLE with `busy`=0.
- **Writes are not deferred.** Words are written as they arrive, before the checksum is checked. A bad checksum only raises `err`; memory is not rolled back.
- **Address update:** after each write, the address increments by 4. It wraps modulo 2^32, so `0xFFFFFFFC` is followed by `0x00000000`.
- **Framing error while `busy`:** abort to IDLE, `busy`=0, `err`=1. Words already written remain in memory.
- **Framing error in IDLE:** ignored. `err` is unchanged.
- **`err` lifetime:** it stays high until the next accepted sync byte or reset.
- **Reset mid-frame:** everything returns to the reset values immediately, including dropping an in-progress strobe.

## Timing
- **Write cycle:** `mem_wstrb`=`1111` for exactly one cycle, in the cycle after the `byte_valid` of the word's 4th byte.
- **Write data validity:** `mem_addr` and `mem_wdata` are stable during that cycle. `mem_addr` advances in the following cycle.
- **Back-to-back writes:** consecutive writes are at least 10×`CLKS_PER_BIT` cycles apart. The bus needs no wait states; `progmem` accepts a write every cycle.
- **`done`:** 1-cycle pulse, in the cycle after the checksum byte's `byte_valid`. `busy` falls in the same cycle.
- **`busy`:** rises in the cycle after the sync byte's `byte_valid`.
- **Byte latency:** from the start-bit falling edge at the pin to `byte_valid` is 2 synchronizer cycles plus 9.5×`CLKS_PER_BIT` ±1 cycle.

## Test plan
- **Good frame, N=2:** frame `A5 00 01 00 00 02 00 EF BE AD DE 78 56 34 12 <sum>` -> writes `0xDEADBEEF` @ `0x00000100` and `0x12345678` @ `0x00000104`; `done` pulses once; `err`=0; `busy` low afterwards.
- **Bad checksum, N=1:** same style of frame with the checksum byte +1 -> the word is still written; `err`=1; no `done` pulse; the next `0xA5` clears `err`.
- **Noise and N=0:** bytes `00 FF 5A` in IDLE, then a frame with N=0 and a correct checksum -> no writes; `busy` stays low through the noise; `done` pulses.
- **Address wrap and alignment:** address `0xFFFFFFFE`, N=2 -> writes at `0xFFFFFFFC` then `0x00000000`.
- **Framing error:** a stop bit of 0 during the 3rd data byte -> abort; `err`=1; `busy`=0; no partial write. A 1-cycle glitch low on `uart_rx` -> no byte is produced.
- **Reset mid-frame:** assert `rst`=0 during the DATA state -> all outputs are 0 at once; after release, a complete good frame loads correctly.
